// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port synchronous dmem
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ} state_t;

  state_t              state, state_nxt;
  logic                sel_p1;
  logic                winner_q;
  logic                last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // Port 1 wins when it is the sole requester or when port 0 was granted last.
  always_comb begin
    sel_p1 = p1_req && (!p0_req || !last_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (p0_req || p1_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = we_q ? IDLE : READ;
      READ:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    p0_gnt   = 1'b0;
    p1_gnt   = 1'b0;
    mem_wren = 1'b0;
    if (state == ACCESS) begin
      p0_gnt   = !winner_q;
      p1_gnt   = winner_q;
      mem_wren = we_q;
    end
  end

  // The request is captured on the sampling edge so a requester may drop req before gnt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      winner_q  <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      if (state == IDLE && (p0_req || p1_req)) begin
        winner_q <= sel_p1;
        last_q   <= sel_p1;
        we_q     <= sel_p1 ? p1_we    : p0_we;
        addr_q   <= sel_p1 ? p1_addr  : p0_addr;
        wdata_q  <= sel_p1 ? p1_wdata : p0_wdata;
      end
      if (state == READ) begin
        if (winner_q) begin
          p1_rdata  <= mem_q;
          p1_rvalid <= 1'b1;
        end else begin
          p0_rdata  <= mem_q;
          p0_rvalid <= 1'b1;
        end
      end
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter with a synchronous dmem model
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [11:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  typedef struct {
    logic        p0_req;
    logic        p0_we;
    logic [11:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p1_req;
    logic        p1_we;
    logic [11:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        e_gnt0;
    logic        e_gnt1;
    logic        e_rv0;
    logic        e_rv1;
    logic        e_wren;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt0"}, {31'b0, p0_gnt}, 32'h0);
    chk({tag, " gnt1"}, {31'b0, p1_gnt}, 32'h0);
    chk({tag, " rv0"}, {31'b0, p0_rvalid}, 32'h0);
    chk({tag, " rv1"}, {31'b0, p1_rvalid}, 32'h0);
    chk({tag, " wren"}, {31'b0, mem_wren}, 32'h0);
    chk({tag, " addr"}, {20'b0, mem_address}, 32'h0);
    chk({tag, " data"}, mem_data, 32'h0);
    chk({tag, " rd0"}, p0_rdata, 32'h0);
    chk({tag, " rd1"}, p1_rdata, 32'h0);
  endtask

  initial begin
    int g, cnt_g1, cnt_rv1, bad;
    logic exp_p1;

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;

    //             p0 req we addr    wdata          p1 req we addr    wdata          g0 g1 r0 r1 wr addr    data           rd0            rd1
    vecs[0]  = '{1'b1, 1'b0, 12'h001, 32'h0,        1'b1, 1'b0, 12'h002, 32'h0,        1,0,0,0,0, 12'h001, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 12'h002, 32'h0,        0,0,0,0,0, 12'h001, 32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 12'h002, 32'h0,        0,0,1,0,0, 12'h001, 32'h0,        32'h11111111, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 12'h002, 32'h0,        0,1,0,0,0, 12'h002, 32'h0,        32'h11111111, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        0,0,0,0,0, 12'h002, 32'h0,        32'h11111111, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        0,0,0,1,0, 12'h002, 32'h0,        32'h11111111, 32'h22222222};
    vecs[6]  = '{1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, 12'h000, 32'h0,        1,0,0,0,1, 12'h010, 32'hDEADBEEF, 32'h11111111, 32'h22222222};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        0,0,0,0,0, 12'h010, 32'hDEADBEEF, 32'h11111111, 32'h22222222};
    vecs[8]  = '{1'b1, 1'b0, 12'h010, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        1,0,0,0,0, 12'h010, 32'h0,        32'h11111111, 32'h22222222};
    vecs[9]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        0,0,0,0,0, 12'h010, 32'h0,        32'h11111111, 32'h22222222};
    vecs[10] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        0,0,1,0,0, 12'h010, 32'h0,        32'hDEADBEEF, 32'h22222222};
    vecs[11] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        0,0,0,0,0, 12'h010, 32'h0,        32'hDEADBEEF, 32'h22222222};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 12'h3FF, 32'hCAFEF00D, 0,1,0,0,1, 12'h3FF, 32'hCAFEF00D, 32'hDEADBEEF, 32'h22222222};
    vecs[13] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        0,0,0,0,0, 12'h3FF, 32'hCAFEF00D, 32'hDEADBEEF, 32'h22222222};

    idle_inputs();
    reset = 1'b0;
    #2;
    chk_all_zero("reset");
    step();
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      p0_req = vecs[i].p0_req; p0_we = vecs[i].p0_we; p0_addr = vecs[i].p0_addr; p0_wdata = vecs[i].p0_wdata;
      p1_req = vecs[i].p1_req; p1_we = vecs[i].p1_we; p1_addr = vecs[i].p1_addr; p1_wdata = vecs[i].p1_wdata;
      step();
      chk($sformatf("v%0d gnt0", i), {31'b0, p0_gnt}, {31'b0, vecs[i].e_gnt0});
      chk($sformatf("v%0d gnt1", i), {31'b0, p1_gnt}, {31'b0, vecs[i].e_gnt1});
      chk($sformatf("v%0d rv0", i), {31'b0, p0_rvalid}, {31'b0, vecs[i].e_rv0});
      chk($sformatf("v%0d rv1", i), {31'b0, p1_rvalid}, {31'b0, vecs[i].e_rv1});
      chk($sformatf("v%0d wren", i), {31'b0, mem_wren}, {31'b0, vecs[i].e_wren});
      chk($sformatf("v%0d addr", i), {20'b0, mem_address}, {20'b0, vecs[i].e_addr});
      chk($sformatf("v%0d data", i), mem_data, vecs[i].e_data);
      chk($sformatf("v%0d rd0", i), p0_rdata, vecs[i].e_rd0);
      chk($sformatf("v%0d rd1", i), p1_rdata, vecs[i].e_rd1);
    end

    // Fairness: both ports hold write requests; last grant was port 1 so port 0 leads.
    idle_inputs();
    p0_req = 1; p0_we = 1; p0_addr = 12'h020; p0_wdata = 32'hA0A0A0A0;
    p1_req = 1; p1_we = 1; p1_addr = 12'h021; p1_wdata = 32'hA1A1A1A1;
    g = 0;
    bad = 0;
    for (int c = 0; c < 40 && g < 10; c++) begin
      step();
      if (p0_gnt && p1_gnt) bad++;
      if (p0_gnt || p1_gnt) begin
        exp_p1 = (g % 2) == 1;
        chk($sformatf("fair grant %0d is p1", g), {31'b0, p1_gnt}, {31'b0, exp_p1});
        g++;
      end
    end
    chk("fair grant count", g, 10);
    chk("fair both gnt", bad, 0);
    idle_inputs();
    step(); step(); step();

    // Request drop: p1 asserts req only for the sampling cycle.
    p1_req = 1; p1_we = 0; p1_addr = 12'h002;
    step();
    chk("drop gnt1", {31'b0, p1_gnt}, 32'h1);
    idle_inputs();
    cnt_g1 = 0;
    cnt_rv1 = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (p1_gnt) cnt_g1++;
      if (p1_rvalid) cnt_rv1++;
    end
    chk("drop extra gnt1", cnt_g1, 0);
    chk("drop rv1 count", cnt_rv1, 1);
    chk("drop rd1", p1_rdata, 32'h22222222);

    // Reset mid-read: p0 read reaches READ, then reset clears everything without a clock.
    p0_req = 1; p0_we = 0; p0_addr = 12'h001;
    step();
    chk("mid gnt0", {31'b0, p0_gnt}, 32'h1);
    idle_inputs();
    step();
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    step();
    reset = 1'b1;
    cnt_rv1 = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (p0_rvalid || p1_rvalid || p0_gnt || p1_gnt) cnt_rv1++;
    end
    chk("midreset no rvalid", cnt_rv1, 0);

    // Pointer must be back at port 1, so port 0 takes the first tie.
    p0_req = 1; p0_we = 1; p0_addr = 12'h030; p0_wdata = 32'h0;
    p1_req = 1; p1_we = 1; p1_addr = 12'h031; p1_wdata = 32'h0;
    step();
    chk("post reset tie gnt0", {31'b0, p0_gnt}, 32'h1);
    chk("post reset tie gnt1", {31'b0, p1_gnt}, 32'h0);
    idle_inputs();
    step(); step();

    // Idle bus: 20 cycles with no requests.
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (mem_wren || p0_gnt || p1_gnt || p0_rvalid || p1_rvalid) bad++;
    end
    chk("idle bus activity", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
